// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch/data requester handshakes plus the memory-side port.
// slave = arbiter side, master = requesters and memory model side.
interface mem_port_arbiter_if;
   logic        i_req;
   logic [15:0] i_addr;
   logic        i_done;
   logic        d_req;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_wr;
   logic        d_done;
   logic [15:0] rdata;
   logic        busy;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_in;
   logic        mem_enable;
   logic        mem_wr;
   logic [15:0] mem_data_out;

   modport slave (
      input  i_req, i_addr, d_req, d_addr, d_wdata, d_wr, mem_data_out,
      output i_done, d_done, rdata, busy, mem_addr, mem_data_in, mem_enable, mem_wr
   );

   modport master (
      output i_req, i_addr, d_req, d_addr, d_wdata, d_wr, mem_data_out,
      input  i_done, d_done, rdata, busy, mem_addr, mem_data_in, mem_enable, mem_wr
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) sequencer for a single-port memory with programmable access latency.
// Optional macro MEM_PORT_ARBITER_RR_EN selects round-robin arbitration instead of fixed D-over-I priority.
module mem_port_arbiter #(
   parameter int LATENCY = 1,
   parameter int CW      = 4
) (
   input logic             clk,
   input logic             rst,
   mem_port_arbiter_if.slave bus
);
   // Out-of-range latency is clamped to what both the legal range and the counter can hold.
   localparam int CMAX  = (1 << CW) - 1;
   localparam int LMAX  = (CMAX < 15) ? CMAX : 15;
   localparam int LAT_C = (LATENCY < 1) ? 1 : ((LATENCY > LMAX) ? LMAX : LATENCY);
   localparam logic [CW-1:0] CNT_INIT = CW'(LAT_C - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          owner_q;
   logic          wr_q;
   logic [15:0]   addr_q;
   logic [15:0]   wdata_q;
   logic [15:0]   rdata_q;
   logic          i_done_q;
   logic          d_done_q;
   logic          busy_q;
   logic          en_q;
   logic          mwr_q;

   logic          sel_d;
   logic          sel_wr;
   logic          any_req;
   logic [15:0]   sel_addr;
   logic [15:0]   sel_wdata;

`ifdef MEM_PORT_ARBITER_RR_EN
   logic          last_q;

   always_comb begin
      sel_d = bus.d_req && (!bus.i_req || !last_q);
   end
`else
   always_comb begin
      sel_d = bus.d_req;
   end
`endif

   // Fetches are always reads, whatever d_wr happens to be.
   always_comb begin
      any_req   = bus.i_req | bus.d_req;
      sel_wr    = sel_d & bus.d_wr;
      sel_addr  = sel_d ? bus.d_addr : bus.i_addr;
      sel_wdata = sel_d ? bus.d_wdata : 16'h0000;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         owner_q  <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         busy_q   <= 1'b0;
         en_q     <= 1'b0;
         mwr_q    <= 1'b0;
`ifdef MEM_PORT_ARBITER_RR_EN
         last_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_q <= ACCESS;
                  cnt_q   <= CNT_INIT;
                  owner_q <= sel_d;
                  wr_q    <= sel_wr;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  en_q    <= 1'b1;
                  mwr_q   <= sel_wr && (CNT_INIT == '0);
                  busy_q  <= 1'b1;
`ifdef MEM_PORT_ARBITER_RR_EN
                  last_q  <= sel_d;
`endif
               end
            end
            ACCESS: begin
               if (cnt_q == '0) begin
                  if (!wr_q) rdata_q <= bus.mem_data_out;
                  en_q     <= 1'b0;
                  mwr_q    <= 1'b0;
                  i_done_q <= !owner_q;
                  d_done_q <= owner_q;
                  state_q  <= RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
                  // Write strobe lines up with the final access cycle only.
                  mwr_q <= wr_q && (cnt_q == CW'(1));
               end
            end
            RESP: begin
               i_done_q <= 1'b0;
               d_done_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.i_done      = i_done_q;
   assign bus.d_done      = d_done_q;
   assign bus.rdata       = rdata_q;
   assign bus.busy        = busy_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_data_in = wdata_q;
   assign bus.mem_enable  = en_q;
   assign bus.mem_wr      = mwr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (LATENCY 1, 3, 4), each with a byte-wide memory model.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic preload;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if b1 ();
   mem_port_arbiter_if b3 ();
   mem_port_arbiter_if b4 ();

   mem_port_arbiter #(.LATENCY(1), .CW(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
   mem_port_arbiter #(.LATENCY(3), .CW(4)) u3 (.clk(clk), .rst(rst), .bus(b3));
   mem_port_arbiter #(.LATENCY(4), .CW(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

   // Big-endian 16-bit view over byte storage; the second byte wraps at 0xFFFF.
   logic [7:0]  m1 [0:65535];
   logic [7:0]  m3 [0:65535];
   logic [7:0]  m4 [0:65535];
   logic [15:0] a1n, a3n, a4n;

   assign a1n = b1.mem_addr + 16'd1;
   assign a3n = b3.mem_addr + 16'd1;
   assign a4n = b4.mem_addr + 16'd1;
   assign b1.mem_data_out = {m1[b1.mem_addr], m1[a1n]};
   assign b3.mem_data_out = {m3[b3.mem_addr], m3[a3n]};
   assign b4.mem_data_out = {m4[b4.mem_addr], m4[a4n]};

   always @(posedge clk) begin
      if (preload) begin
         m1[16'h0100] <= 8'hAB; m1[16'h0101] <= 8'hCD;
         m1[16'h0300] <= 8'h5A; m1[16'h0301] <= 8'hA5;
         m1[16'hFFFF] <= 8'h11; m1[16'h0000] <= 8'h22;
      end else if (b1.mem_enable && b1.mem_wr) begin
         m1[b1.mem_addr] <= b1.mem_data_in[15:8]; m1[a1n] <= b1.mem_data_in[7:0];
      end
   end

   always @(posedge clk) begin
      if (preload) begin
         m3[16'h0200] <= 8'h00; m3[16'h0201] <= 8'h00;
      end else if (b3.mem_enable && b3.mem_wr) begin
         m3[b3.mem_addr] <= b3.mem_data_in[15:8]; m3[a3n] <= b3.mem_data_in[7:0];
      end
   end

   always @(posedge clk) begin
      if (preload) begin
         m4[16'h0400] <= 8'h77; m4[16'h0401] <= 8'h88;
      end else if (b4.mem_enable && b4.mem_wr) begin
         m4[b4.mem_addr] <= b4.mem_data_in[15:8]; m4[a4n] <= b4.mem_data_in[7:0];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      preload = 1'b1;
      b1.i_req = 0; b1.i_addr = 0; b1.d_req = 0; b1.d_addr = 0; b1.d_wdata = 0; b1.d_wr = 0;
      b3.i_req = 0; b3.i_addr = 0; b3.d_req = 0; b3.d_addr = 0; b3.d_wdata = 0; b3.d_wr = 0;
      b4.i_req = 0; b4.i_addr = 0; b4.d_req = 0; b4.d_addr = 0; b4.d_wdata = 0; b4.d_wr = 0;
      repeat (2) tick();
      preload = 1'b0;

      check("rst_ctl",   {b1.i_done, b1.d_done, b1.busy, b1.mem_enable, b1.mem_wr}, 0);
      check("rst_rdata", b1.rdata, 0);
      check("rst_maddr", b1.mem_addr, 0);
      check("rst_mdin",  b1.mem_data_in, 0);
      rst = 1'b1;
      tick();
      check("idle_en", {b1.mem_enable, b1.mem_wr, b1.busy}, 0);

      // Fetch, LATENCY=1; d_wr high must not turn the fetch into a store.
      b1.i_addr = 16'h0100; b1.d_wr = 1'b1; b1.i_req = 1'b1;
      tick();
      check("f_acc",   {b1.busy, b1.mem_enable, b1.mem_wr, b1.i_done}, 4'b1100);
      check("f_maddr", b1.mem_addr, 16'h0100);
      tick();
      check("f_done",  {b1.i_done, b1.d_done, b1.mem_enable, b1.busy}, 4'b1001);
      check("f_rdata", b1.rdata, 16'hABCD);
      b1.i_req = 1'b0; b1.d_wr = 1'b0;
      tick();
      check("f_idle",  {b1.i_done, b1.busy}, 0);

      // Store then load, LATENCY=3.
      b3.d_addr = 16'h0200; b3.d_wdata = 16'h1234; b3.d_wr = 1'b1; b3.d_req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         check("st_wr",   b3.mem_wr, (c == 3));
         check("st_done", b3.d_done, (c == 4));
         if (c == 4) begin
            check("st_rdata_keep", b3.rdata, 16'h0000);
            check("st_busy", b3.busy, 1);
            b3.d_req = 1'b0;
         end
      end
      tick();
      check("st_mem", {m3[16'h0200], m3[16'h0201]}, 16'h1234);
      b3.d_wr = 1'b0; b3.d_req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         check("ld_done", b3.d_done, (c == 4));
         if (c == 4) begin
            check("ld_rdata", b3.rdata, 16'h1234);
            b3.d_req = 1'b0;
         end
      end
      tick();

      // Collision, LATENCY=1: D served first, I waits.
      b1.i_addr = 16'h0100; b1.i_req = 1'b1;
      b1.d_addr = 16'h0300; b1.d_wr = 1'b0; b1.d_req = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         check("col_d", b1.d_done, (c == 2));
         check("col_i", b1.i_done, (c == 5));
         if (c == 2) begin
            check("col_drdata", b1.rdata, 16'h5AA5);
            b1.d_req = 1'b0;
         end
         if (c == 5) begin
            check("col_irdata", b1.rdata, 16'hABCD);
            b1.i_req = 1'b0;
         end
      end
      tick();

      // Back-to-back data loads, second one at the wrapping address.
      b1.d_addr = 16'h0300; b1.d_req = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         check("b2b_done", b1.d_done, (c == 2 || c == 5));
         if (c == 2) b1.d_addr = 16'hFFFF;
         if (c == 4) check("b2b_maddr", b1.mem_addr, 16'hFFFF);
         if (c == 5) begin
            check("b2b_wrap", b1.rdata, 16'h1122);
            b1.d_req = 1'b0;
         end
      end
      tick();

      // Reset in the first access cycle of a LATENCY=4 store.
      b4.d_addr = 16'h0400; b4.d_wdata = 16'hBEEF; b4.d_wr = 1'b1; b4.d_req = 1'b1;
      tick();
      check("rs_acc", {b4.busy, b4.mem_enable, b4.mem_wr}, 3'b110);
      rst = 1'b0; b4.d_req = 1'b0;
      tick();
      check("rs_ctl",   {b4.i_done, b4.d_done, b4.busy, b4.mem_enable, b4.mem_wr}, 0);
      check("rs_maddr", b4.mem_addr, 0);
      check("rs_mdin",  b4.mem_data_in, 0);
      check("rs_rdata", b4.rdata, 0);
      rst = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         check("rs_quiet", {b4.mem_wr, b4.d_done, b4.busy}, 0);
      end
      check("rs_mem", {m4[16'h0400], m4[16'h0401]}, 16'h7788);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
